// File: rtl/sdram_read.sv
// ---------------------------------------------------------------------------
// sdram_read -- burst read engine for a single-bank SDRAM port.
//
// A one-cycle rd_trig starts a transaction of rd_len 4-word bursts from a
// 4-word aligned word address. The engine asks the arbiter for the bus,
// opens the row (ACT + tRCD), streams READ commands every 4 cycles, and
// closes the row (PRE + tRP). It releases the bus between rows when the
// grant is lost, and re-opens the next row by itself when a burst
// crosses a row boundary.
//
// Ports
//   sclk, srst_n       clock (rising edge), asynchronous active-low reset
//   rd_en              arbiter grant
//   flag_rd_ask        bus request (state is ASK)
//   flag_rd_end        one-cycle pulse when the bus is handed back
//   rd_trig            start pulse
//   rd_len             number of 4-word bursts
//   rd_addr            start word address {row[11:0], col[8:0]}
//   sdram_dq_in        data from the SDRAM
//   rd_data            registered read data
//   rd_data_vld        rd_data qualifier
//   sdram_cmd          registered {CS,RAS,CAS,WE}
//   sdram_addr         registered SDRAM address bus
//   sdram_bank         bank select, always bank 0
//   busy               engine is not idle
// ---------------------------------------------------------------------------
module sdram_read #(
    parameter int CAS_LAT = 3,   // 2 or 3
    parameter int DATA_W  = 16
) (
    input  logic              sclk,
    input  logic              srst_n,
    input  logic              rd_en,
    output logic              flag_rd_ask,
    output logic              flag_rd_end,
    input  logic              rd_trig,
    input  logic [7:0]        rd_len,
    input  logic [20:0]       rd_addr,
    input  logic [DATA_W-1:0] sdram_dq_in,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic [3:0]        sdram_cmd,
    output logic [11:0]       sdram_addr,
    output logic [1:0]        sdram_bank,
    output logic              busy
);

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_ASK  = 5'b00010;
    localparam logic [4:0] S_ACT  = 5'b00100;
    localparam logic [4:0] S_RD   = 5'b01000;
    localparam logic [4:0] S_PRE  = 5'b10000;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_PRE  = 4'b0010;

    logic [4:0]  state, state_nx;
    logic        phase, phase_nx;        // second cycle of ACT / PRE
    logic [1:0]  burst_cnt, burst_nx;
    logic [11:0] row, row_nx;
    logic [8:0]  col, col_nx;
    logic [7:0]  remaining, rem_nx;
    logic        row_cross, cross_nx;
    logic        end_nx;
    logic [3:0]  cmd_nx;
    logic [11:0] addr_nx;
    logic [9:0]  col_sum;

    assign col_sum     = {1'b0, col} + 10'd4;
    assign flag_rd_ask = (state == S_ASK);
    assign busy        = (state != S_IDLE);
    assign sdram_bank  = 2'b00;

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        burst_nx = burst_cnt;
        row_nx   = row;
        col_nx   = col;
        rem_nx   = remaining;
        cross_nx = row_cross;
        end_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rd_trig && rd_len != 8'd0) begin
                    row_nx   = rd_addr[20:9];
                    col_nx   = rd_addr[8:0];
                    rem_nx   = rd_len;
                    state_nx = S_ASK;
                end
            end
            S_ASK: begin
                if (rd_en) begin
                    state_nx = S_ACT;
                    phase_nx = 1'b0;
                end
            end
            S_ACT: begin
                if (!phase) begin
                    phase_nx = 1'b1;
                end else begin
                    state_nx = S_RD;
                    burst_nx = 2'd0;
                end
            end
            S_RD: begin
                // burst_cnt wraps 3->0, which starts the next burst
                burst_nx = burst_cnt + 2'd1;
                if (burst_cnt == 2'd1) begin
                    rem_nx = remaining - 8'd1;
                    col_nx = col_sum[8:0];
                    if (col_sum[9]) cross_nx = 1'b1;
                end
                if (burst_cnt == 2'd3 &&
                    (remaining == 8'd0 || row_cross || !rd_en)) begin
                    state_nx = S_PRE;
                    phase_nx = 1'b0;
                end
            end
            S_PRE: begin
                if (!phase) begin
                    phase_nx = 1'b1;
                end else begin
                    if (row_cross) begin
                        row_nx   = row + 12'd1;
                        cross_nx = 1'b0;
                    end
                    if (remaining == 8'd0) begin
                        state_nx = S_IDLE;
                        end_nx   = 1'b1;
                    end else if (rd_en) begin
                        state_nx = S_ACT;
                        phase_nx = 1'b0;
                    end else begin
                        state_nx = S_ASK;
                        end_nx   = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Command is decoded from the next state so that the registered
    // sdram_cmd lines up with the state it belongs to.
    always_comb begin
        cmd_nx  = CMD_NOP;
        addr_nx = 12'h000;
        if (state_nx == S_ACT && !phase_nx) begin
            cmd_nx  = CMD_ACT;
            addr_nx = row_nx;
        end else if (state_nx == S_RD && burst_nx == 2'd0) begin
            cmd_nx  = CMD_READ;
            addr_nx = {3'b000, col_nx};
        end else if (state_nx == S_PRE && !phase_nx) begin
            cmd_nx  = CMD_PRE;
            addr_nx = 12'h400;
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state       <= S_IDLE;
            phase       <= 1'b0;
            burst_cnt   <= 2'd0;
            row         <= 12'h000;
            col         <= 9'h000;
            remaining   <= 8'd0;
            row_cross   <= 1'b0;
            flag_rd_end <= 1'b0;
            sdram_cmd   <= CMD_NOP;
            sdram_addr  <= 12'h000;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            burst_cnt   <= burst_nx;
            row         <= row_nx;
            col         <= col_nx;
            remaining   <= rem_nx;
            row_cross   <= cross_nx;
            flag_rd_end <= end_nx;
            sdram_cmd   <= cmd_nx;
            sdram_addr  <= addr_nx;
        end
    end

    // ---- stage p0: READ issue history, bit k = READ seen k+1 cycles ago.
    // Data returns CAS_LAT cycles after the READ and lasts 4 words, so the
    // capture window is bits CAS_LAT-1 .. CAS_LAT+2.
    logic [CAS_LAT+2:0] rd_vld_sr_p0;
    logic               cap_vld_p0;

    assign cap_vld_p0 = |rd_vld_sr_p0[CAS_LAT+2:CAS_LAT-1];

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            rd_vld_sr_p0 <= '0;
        end else begin
            rd_vld_sr_p0 <= {rd_vld_sr_p0[CAS_LAT+1:0], (sdram_cmd == CMD_READ)};
        end
    end

    // ---- stage p1: registered read data and valid
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            rd_data     <= '0;
            rd_data_vld <= 1'b0;
        end else begin
            rd_data_vld <= cap_vld_p0;
            if (cap_vld_p0) rd_data <= sdram_dq_in;
        end
    end

endmodule

// File: tb/tb_sdram_read.sv
// ---------------------------------------------------------------------------
// tb_sdram_read -- scoreboard bench for sdram_read (CAS_LAT = 3).
// Expected commands, read data and end pulses are queued with their cycle
// numbers when a transaction is started; a monitor pops and compares them
// as the DUT produces them. sdram_dq_in is a known function of the cycle
// number so the expected data for each READ is computed up front.
// ---------------------------------------------------------------------------
module tb_sdram_read;

    localparam int CL = 3;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] ACT  = 4'b0011;
    localparam logic [3:0] RDC  = 4'b0101;
    localparam logic [3:0] PRE  = 4'b0010;

    logic        sclk = 1'b0;
    logic        srst_n = 1'b0;
    logic        rd_en = 1'b1;
    logic        rd_trig = 1'b0;
    logic [7:0]  rd_len = 8'd0;
    logic [20:0] rd_addr = 21'd0;
    logic [15:0] sdram_dq_in;
    logic        flag_rd_ask, flag_rd_end, rd_data_vld, busy;
    logic [15:0] rd_data;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;

    int cyc = 0;
    int n_total = 0;
    int n_bad = 0;

    typedef struct { int cyc; logic [3:0] cmd; logic [11:0] addr; } cmd_exp_t;
    typedef struct { int cyc; logic [15:0] d; } dat_exp_t;
    cmd_exp_t cmd_q[$];
    dat_exp_t dat_q[$];
    int       end_q[$];

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    function automatic logic [15:0] dq_fn(input int t);
        return 16'(t * 945) ^ 16'h5A5A;
    endfunction

    assign sdram_dq_in = dq_fn(cyc);

    sdram_read #(.CAS_LAT(CL)) dut (
        .sclk        (sclk),
        .srst_n      (srst_n),
        .rd_en       (rd_en),
        .flag_rd_ask (flag_rd_ask),
        .flag_rd_end (flag_rd_end),
        .rd_trig     (rd_trig),
        .rd_len      (rd_len),
        .rd_addr     (rd_addr),
        .sdram_dq_in (sdram_dq_in),
        .rd_data     (rd_data),
        .rd_data_vld (rd_data_vld),
        .sdram_cmd   (sdram_cmd),
        .sdram_addr  (sdram_addr),
        .sdram_bank  (sdram_bank),
        .busy        (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge sclk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic exp_cmd(input int c, input logic [3:0] cmd, input logic [11:0] a);
        cmd_q.push_back('{c, cmd, a});
    endtask

    task automatic exp_read(input int c, input logic [8:0] col, input bit with_data);
        exp_cmd(c, RDC, {3'b000, col});
        if (with_data)
            for (int k = 0; k < 4; k++) dat_q.push_back('{c + CL + 1 + k, dq_fn(c + CL + k)});
    endtask

    task automatic exp_end(input int c);
        end_q.push_back(c);
    endtask

    task automatic trig(input logic [20:0] a, input logic [7:0] n, output int c0);
        rd_addr = a;
        rd_len  = n;
        rd_trig = 1'b1;
        c0 = cyc;
        tick();
        rd_trig = 1'b0;
    endtask

    task automatic drain();
        check_eq("cmd_q_left", 32'(cmd_q.size()), 32'd0);
        check_eq("dat_q_left", 32'(dat_q.size()), 32'd0);
        check_eq("end_q_left", 32'(end_q.size()), 32'd0);
        cmd_q.delete();
        dat_q.delete();
        end_q.delete();
    endtask

    // Monitor: every non-NOP command, valid data word and end pulse must
    // match the head of its queue, both in value and in cycle.
    initial begin
        cmd_exp_t   ce;
        dat_exp_t   de;
        int         ee;
        logic [3:0] prev_cmd;
        prev_cmd = NOP;
        forever begin
            @(negedge sclk);
            if (sdram_cmd !== NOP) begin
                check_eq("adj_cmd", 32'(prev_cmd), 32'(NOP));
                check_eq("bank", 32'(sdram_bank), 32'd0);
                if (cmd_q.size() == 0) begin
                    check_eq("cmd_unexp", 32'(sdram_cmd), 32'(NOP));
                end else begin
                    ce = cmd_q.pop_front();
                    check_eq("cmd_cyc", 32'(cyc), 32'(ce.cyc));
                    check_eq("cmd", 32'(sdram_cmd), 32'(ce.cmd));
                    check_eq("cmd_addr", 32'(sdram_addr), 32'(ce.addr));
                end
            end
            prev_cmd = sdram_cmd;
            if (rd_data_vld) begin
                if (dat_q.size() == 0) begin
                    check_eq("vld_unexp", 32'(rd_data_vld), 32'd0);
                end else begin
                    de = dat_q.pop_front();
                    check_eq("vld_cyc", 32'(cyc), 32'(de.cyc));
                    check_eq("rd_data", 32'(rd_data), 32'(de.d));
                end
            end
            if (flag_rd_end) begin
                if (end_q.size() == 0) begin
                    check_eq("end_unexp", 32'(flag_rd_end), 32'd0);
                end else begin
                    ee = end_q.pop_front();
                    check_eq("end_cyc", 32'(cyc), 32'(ee));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int cd;
        tick();
        tick();
        // reset values
        check_eq("rst_cmd", 32'(sdram_cmd), 32'(NOP));
        check_eq("rst_addr", 32'(sdram_addr), 32'd0);
        check_eq("rst_bank", 32'(sdram_bank), 32'd0);
        check_eq("rst_data", 32'(rd_data), 32'd0);
        check_eq("rst_vld", 32'(rd_data_vld), 32'd0);
        check_eq("rst_ask", 32'(flag_rd_ask), 32'd0);
        check_eq("rst_end", 32'(flag_rd_end), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        srst_n = 1'b1;
        tick();
        tick();

        // single burst, row 0x005 col 0x008
        trig(21'h00A08, 8'd1, c0);
        check_eq("s1_ask", 32'(flag_rd_ask), 32'd1);
        check_eq("s1_busy", 32'(busy), 32'd1);
        exp_cmd(c0 + 2, ACT, 12'h005);
        exp_read(c0 + 4, 9'h008, 1'b1);
        exp_cmd(c0 + 8, PRE, 12'h400);
        exp_end(c0 + 10);
        wait_cyc(c0 + 10);
        check_eq("s1_idle", 32'(busy), 32'd0);
        wait_cyc(c0 + 14);
        drain();

        // three back-to-back bursts in one row
        trig(21'h00600, 8'd3, c0);
        exp_cmd(c0 + 2, ACT, 12'h003);
        for (int i = 0; i < 3; i++) exp_read(c0 + 4 + 4 * i, 9'(4 * i), 1'b1);
        exp_cmd(c0 + 16, PRE, 12'h400);
        exp_end(c0 + 18);
        wait_cyc(c0 + 22);
        drain();

        // row crossing: col 0x1FC in row 0x010 then col 0 in row 0x011
        trig(21'h021FC, 8'd2, c0);
        exp_cmd(c0 + 2, ACT, 12'h010);
        exp_read(c0 + 4, 9'h1FC, 1'b1);
        exp_cmd(c0 + 8, PRE, 12'h400);
        exp_cmd(c0 + 10, ACT, 12'h011);
        exp_read(c0 + 12, 9'h000, 1'b1);
        exp_cmd(c0 + 16, PRE, 12'h400);
        exp_end(c0 + 18);
        wait_cyc(c0 + 22);
        drain();

        // grant lost in burst 2 of 4, then re-granted
        trig(21'h00E10, 8'd4, c0);
        exp_cmd(c0 + 2, ACT, 12'h007);
        exp_read(c0 + 4, 9'h010, 1'b1);
        exp_read(c0 + 8, 9'h014, 1'b1);
        exp_cmd(c0 + 12, PRE, 12'h400);
        exp_end(c0 + 14);
        exp_cmd(c0 + 17, ACT, 12'h007);
        exp_read(c0 + 19, 9'h018, 1'b1);
        exp_read(c0 + 23, 9'h01C, 1'b1);
        exp_cmd(c0 + 27, PRE, 12'h400);
        exp_end(c0 + 29);
        wait_cyc(c0 + 9);
        rd_en = 1'b0;
        wait_cyc(c0 + 15);
        check_eq("s4_ask_hold", 32'(flag_rd_ask), 32'd1);
        check_eq("s4_busy", 32'(busy), 32'd1);
        wait_cyc(c0 + 16);
        rd_en = 1'b1;
        wait_cyc(c0 + 33);
        drain();

        // rd_len == 0 ignored in IDLE; rd_trig ignored during RD
        trig(21'h1FFFF0, 8'd0, c0);
        check_eq("s5_len0_busy", 32'(busy), 32'd0);
        check_eq("s5_len0_ask", 32'(flag_rd_ask), 32'd0);
        tick();
        trig(21'h04040, 8'd2, c0);
        exp_cmd(c0 + 2, ACT, 12'h020);
        exp_read(c0 + 4, 9'h040, 1'b1);
        exp_read(c0 + 8, 9'h044, 1'b1);
        exp_cmd(c0 + 12, PRE, 12'h400);
        exp_end(c0 + 14);
        wait_cyc(c0 + 6);
        trig(21'h1FFFF0, 8'd9, cd);
        wait_cyc(c0 + 18);
        drain();

        // reset one cycle after the first READ
        trig(21'h00A08, 8'd2, c0);
        exp_cmd(c0 + 2, ACT, 12'h005);
        exp_read(c0 + 4, 9'h008, 1'b0);
        wait_cyc(c0 + 5);
        srst_n = 1'b0;
        #1;
        check_eq("s6_rst_cmd", 32'(sdram_cmd), 32'(NOP));
        check_eq("s6_rst_vld", 32'(rd_data_vld), 32'd0);
        check_eq("s6_rst_busy", 32'(busy), 32'd0);
        tick();
        srst_n = 1'b1;
        wait_cyc(c0 + 18);
        drain();
        trig(21'h00A08, 8'd1, c0);
        exp_cmd(c0 + 2, ACT, 12'h005);
        exp_read(c0 + 4, 9'h008, 1'b1);
        exp_cmd(c0 + 8, PRE, 12'h400);
        exp_end(c0 + 10);
        wait_cyc(c0 + 14);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_read.md
SDRAM_READ -- requirements
Module: sdram_read

Interface
REQ-001 Parameter: CAS_LAT, default 3, CAS latency in sclk cycles; legal values are 2 and 3.
REQ-002 sclk  in  1  clock; all logic is rising-edge.
REQ-003 srst_n  in  1  reset, asynchronous, active-low.
REQ-004 rd_en  in  1  arbiter grant; high means the block may drive the SDRAM bus.
REQ-005 flag_rd_ask  out  1  bus request to the arbiter.
REQ-006 flag_rd_end  out  1  one-cycle pulse when the bus is released.
REQ-007 rd_trig  in  1  one-cycle start pulse.
REQ-008 rd_len  in  8  number of 4-word bursts to read.
REQ-009 rd_addr  in  21  start word address: row = [20:9], col = [8:0]; must be 4-word aligned.
REQ-010 sdram_dq_in  in  16  data returned by the SDRAM.
REQ-011 rd_data  out  16  registered read data.
REQ-012 rd_data_vld  out  1  rd_data is valid in this cycle.
REQ-013 sdram_cmd  out  4  registered {CS,RAS,CAS,WE}: NOP 0111, ACT 0011, READ 0101, PRE 0010.
REQ-014 sdram_addr  out  12  row during ACT; {3'b0,col} during READ; 12'h400 (A10 set, all banks) during PRE.
REQ-015 sdram_bank  out  2  constant 0.
REQ-016 busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 States are IDLE, ASK, ACT, RD and PRE, one-hot encoded.
REQ-018 IDLE: rd_trig with rd_len!=0 latches row, col and remaining=rd_len, then goes to ASK on the next cycle.
REQ-019 IDLE: rd_trig with rd_len==0 is ignored.
REQ-020 rd_trig outside IDLE is ignored; latched values are unchanged.
REQ-021 flag_rd_ask is combinational and equals (state==ASK).
REQ-022 ASK goes to ACT when rd_en is sampled high; otherwise ASK holds.
REQ-023 ACT lasts exactly 2 cycles: sdram_cmd=ACT with row on sdram_addr, then NOP (tRCD); the next state is RD.
REQ-024 RD uses a 2-bit burst_cnt, cleared on RD entry and incrementing each cycle in RD.
REQ-025 RD: a READ command with the current col is issued when burst_cnt==0; sdram_cmd is NOP in the other three cycles.
REQ-026 RD: at burst_cnt==1, remaining decrements and col <= col+4 using 10-bit arithmetic.
REQ-027 RD: a carry out of bit 8 on that add sets row_cross, and col wraps to 0.
REQ-028 RD exits to PRE at burst_cnt==3 if remaining==0, or row_cross==1, or rd_en==0; otherwise the next burst starts.
REQ-029 Consecutive READ commands are therefore exactly 4 cycles apart.
REQ-030 PRE lasts exactly 2 cycles: sdram_cmd=PRE with sdram_addr=12'h400, then NOP (tRP).
REQ-031 PRE exit when remaining==0: go to IDLE and pulse flag_rd_end.
REQ-032 PRE exit with remaining!=0 and rd_en high: go to ACT, with no flag_rd_end pulse.
REQ-033 PRE exit with remaining!=0 and rd_en low: go to ASK and pulse flag_rd_end.
REQ-034 On leaving PRE, if row_cross is set, row increments (12-bit, wraps) and row_cross clears.
REQ-035 Data path: a READ on sdram_cmd in cycle T means sdram_dq_in is sampled at cycles T+CAS_LAT .. T+CAS_LAT+3.
REQ-036 Data path: rd_data carries those samples, and rd_data_vld is high, during cycles T+CAS_LAT+1 .. T+CAS_LAT+4.
REQ-037 The data valid pipeline is a shift register independent of the state machine and keeps running through PRE, IDLE and ASK.
REQ-038 Total rd_data_vld cycles per transaction = 4 × (bursts actually issued); the transaction completes only when rd_len bursts have been issued.
REQ-039 sdram_cmd is NOP in IDLE and ASK.
REQ-040 sdram_cmd never carries two non-NOP commands in adjacent cycles.

Reset
REQ-041 srst_n low asynchronously forces: state=IDLE, sdram_cmd=NOP, sdram_addr=0, sdram_bank=0.
REQ-042 srst_n low also forces: rd_data=0, rd_data_vld=0, flag_rd_ask=0, flag_rd_end=0, busy=0.
REQ-043 srst_n low clears row, col, remaining, burst_cnt, row_cross and the valid pipeline; this holds mid-transaction too.
REQ-044 After a reset mid-transaction, no rd_data_vld is produced for READs already issued.

Verification
REQ-045 rd_trig, rd_addr=0x00A08, rd_len=1, rd_en=1 -> ACT with row 0x005, NOP, READ col 0x008, PRE 0x400, IDLE, flag_rd_end pulse, exactly 4 rd_data_vld at READ+4..+7 (CAS_LAT=3).
REQ-046 rd_len=3, rd_en held high -> READs to col 0,4,8 spaced 4 cycles apart, a single ACT/PRE pair, and 12 contiguous rd_data_vld cycles.
REQ-047 rd_addr col=0x1FC, row=0x010, rd_len=2 -> READ col 0x1FC in row 0x010, PRE, ACT row 0x011, READ col 0x000, PRE, IDLE; no flag_rd_end between the two rows.
REQ-048 rd_len=4, rd_en dropped during the second burst -> PRE after burst 2, flag_rd_end pulse, ASK with remaining=2; re-grant gives ACT on the same row, READ col+8, and 16 vld cycles in total.
REQ-049 srst_n pulsed low 1 cycle after the first READ -> sdram_cmd=NOP and rd_data_vld=0 immediately; no valid data afterwards; IDLE accepts a new rd_trig.
REQ-050 rd_trig during RD, and rd_trig with rd_len=0 in IDLE -> both ignored; the active transaction is unaltered.
